// File: rtl/clkdiv_pkg.sv
// Shared types, limits and helpers for the clkdiv_bank divider channels.
package clkdiv_pkg;

  localparam int unsigned DW_DEFAULT = 8;
  localparam int unsigned CH_MAX     = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } chan_state_t;

  // Counter threshold at which clk_p goes high: ceil(n/2).
  function automatic int unsigned half_up(input int unsigned n);
    return (n >> 1) + (n & 32'd1);
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: IDLE/RUN/DRAIN FSM, period counter, clk_p, bypass select.
// CLKDIV_ODD_DUTY50_EN adds the negedge copy clk_n for 50 % duty on odd ratios.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] divide,
  input  logic          enable,
  input  logic          sync,
  output logic          clkout,
  output logic          active,
  output logic          load_done
);

  chan_state_t   state, state_next;
  logic [DW-1:0] cnt, cnt_next;
  logic [DW-1:0] n_lat, n_next;
  logic [DW-1:0] l_val;
  logic          clk_p, clk_p_next;
  logic          load_next;
  logic          byp, wrap;
  logic          byp_sel;
  logic          hi, quiet;

  assign byp   = (n_lat <= DW'(1));
  assign l_val = DW'(half_up(32'(n_lat)));
  // In bypass every posedge counts as a wrap, so ratio changes land at once.
  assign wrap  = byp || (cnt == n_lat - DW'(1));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    n_next     = n_lat;
    load_next  = 1'b0;
    clk_p_next = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (enable) begin
          state_next = RUN;
          n_next     = divide;
          load_next  = 1'b1;
        end
      end
      default: begin
        cnt_next   = wrap ? '0 : cnt + DW'(1);
        clk_p_next = !byp && (cnt >= l_val);
        if (enable) begin
          state_next = RUN;
          if (wrap && (divide != n_lat)) begin
            n_next    = divide;
            load_next = 1'b1;
          end
        end else begin
          state_next = wrap ? IDLE : DRAIN;
        end
        if ((state == RUN) && sync) begin
          cnt_next   = '0;
          clk_p_next = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      n_lat     <= '0;
      clk_p     <= 1'b0;
      load_done <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      n_lat     <= n_next;
      clk_p     <= clk_p_next;
      load_done <= load_next;
    end
  end

`ifdef CLKDIV_ODD_DUTY50_EN
  logic clk_po, clk_n;

  // Odd-qualified twin of clk_p, using the ratio in force when clk_p was set,
  // so an even->odd change cannot stretch the last old-ratio pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_po <= 1'b0;
    else        clk_po <= clk_p_next & n_lat[0];
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) clk_n <= 1'b0;
    else        clk_n <= clk_po;
  end

  assign hi    = clk_p | clk_n;
  assign quiet = !clk_p && !clk_n;
`else
  assign hi    = clk_p;
  assign quiet = !clk_p;
`endif

  // Select only moves on a falling clk edge while the divided path is low.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)     byp_sel <= 1'b0;
    else if (quiet) byp_sel <= (state != IDLE) && byp;
  end

  assign clkout = byp_sel ? clk : hi;
  assign active = (state != IDLE);

endmodule

// File: rtl/clkdiv_bank.sv
// CH independent integer clock dividers sharing one source clock and sync pulse.
// Optional build macro: CLKDIV_ODD_DUTY50_EN (50 % duty on odd ratios).
module clkdiv_bank
  import clkdiv_pkg::*;
#(
  parameter int unsigned CH = 4,
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*DW-1:0] divide_in,
  input  logic [CH-1:0]    enable,
  input  logic             sync,
  output logic [CH-1:0]    clkout,
  output logic [CH-1:0]    active,
  output logic [CH-1:0]    load_done
);

  for (genvar c = 0; c < CH; c++) begin : g_chan
    clkdiv_chan #(
      .DW(DW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .divide    (divide_in[c*DW +: DW]),
      .enable    (enable[c]),
      .sync      (sync),
      .clkout    (clkout[c]),
      .active    (active[c]),
      .load_done (load_done[c])
    );
  end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Directed self-checking bench for clkdiv_bank (CH=4, DW=8).
module tb_clkdiv_bank;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 8;

`ifdef CLKDIV_ODD_DUTY50_EN
  localparam logic [9:0]  ODD_POS = 10'b1100111000;
  localparam logic [11:0] CHG_POS = 12'b101100111000;
`else
  localparam logic [9:0]  ODD_POS = 10'b1100011000;
  localparam logic [11:0] CHG_POS = 12'b100100111000;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [CH*DW-1:0] divide_in = '0;
  logic [CH-1:0]    enable = '0;
  logic             sync = 1'b0;
  logic [CH-1:0]    clkout, active, load_done;

  int errors = 0;
  int checks = 0;
  logic [CH-1:0] cp, cn, ld, ac;

  always #5 clk = ~clk;

  clkdiv_bank #(
    .CH(CH),
    .DW(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .divide_in (divide_in),
    .enable    (enable),
    .sync      (sync),
    .clkout    (clkout),
    .active    (active),
    .load_done (load_done)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // One source cycle: sample just after the posedge and just after the negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    cp = clkout;
    ld = load_done;
    ac = active;
    @(negedge clk);
    #1;
    cn = clkout;
  endtask

  task automatic set_div(input int c, input logic [DW-1:0] n);
    divide_in[c*DW +: DW] = n;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = '0;
    sync = 1'b0;
    divide_in = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (clkout !== 4'b0000) begin errors++; $display("FAIL reset_clkout got=%b want=%b", clkout, 4'b0000); end
    checks++;
    if (active !== 4'b0000) begin errors++; $display("FAIL reset_active got=%b want=%b", active, 4'b0000); end
    checks++;
    if (load_done !== 4'b0000) begin errors++; $display("FAIL reset_load_done got=%b want=%b", load_done, 4'b0000); end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({cp, cn, ac, ld} !== 16'h0000) begin
      errors++; $display("FAIL reset_idle got=%h want=%h", {cp, cn, ac, ld}, 16'h0000);
    end
  endtask

  task automatic test_even();
    logic [7:0] vp, vn;
    logic       ld1;
    do_reset();
    set_div(0, 8'd4);
    enable[0] = 1'b1;
    tick();
    checks++;
    if (ac[0] !== 1'b1) begin errors++; $display("FAIL even_active got=%b want=1", ac[0]); end
    checks++;
    if (ld[0] !== 1'b1) begin errors++; $display("FAIL even_load_done got=%b want=1", ld[0]); end
    checks++;
    if (cp[0] !== 1'b0) begin errors++; $display("FAIL even_first got=%b want=0", cp[0]); end
    ld1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      vp[i-1] = cp[0];
      vn[i-1] = cn[0];
      if (i == 1) ld1 = ld[0];
    end
    checks++;
    if (ld1 !== 1'b0) begin errors++; $display("FAIL even_load_pulse got=%b want=0", ld1); end
    checks++;
    if (vp !== 8'b11001100) begin errors++; $display("FAIL even_pos got=%b want=%b", vp, 8'b11001100); end
    checks++;
    if (vn !== 8'b11001100) begin errors++; $display("FAIL even_neg got=%b want=%b", vn, 8'b11001100); end
  endtask

  task automatic test_odd();
    logic [9:0] vp, vn;
    do_reset();
    set_div(1, 8'd5);
    enable[1] = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      tick();
      vp[i-1] = cp[1];
      vn[i-1] = cn[1];
    end
    checks++;
    if (vp !== ODD_POS) begin errors++; $display("FAIL odd_pos got=%b want=%b", vp, ODD_POS); end
    checks++;
    if (vn !== 10'b1100011000) begin errors++; $display("FAIL odd_neg got=%b want=%b", vn, 10'b1100011000); end
  endtask

  task automatic test_ratio_change();
    logic [11:0] vp, vn, vl;
    do_reset();
    set_div(2, 8'd6);
    enable[2] = 1'b1;
    tick();
    for (int i = 1; i <= 12; i++) begin
      tick();
      vp[i-1] = cp[2];
      vn[i-1] = cn[2];
      vl[i-1] = ld[2];
      if (i == 2) set_div(2, 8'd7);
      if (i == 3) set_div(2, 8'd3);
    end
    checks++;
    if (vp !== CHG_POS) begin errors++; $display("FAIL chg_pos got=%b want=%b", vp, CHG_POS); end
    checks++;
    if (vn !== 12'b100100111000) begin errors++; $display("FAIL chg_neg got=%b want=%b", vn, 12'b100100111000); end
    checks++;
    if (vl !== 12'b000000100000) begin errors++; $display("FAIL chg_load_done got=%b want=%b", vl, 12'b000000100000); end
  endtask

  task automatic test_bypass();
    logic [3:0]  bp, bn;
    logic [15:0] vp, vn;
    logic        ldsw;
    do_reset();
    set_div(3, 8'd0);
    enable[3] = 1'b1;
    tick();
    checks++;
    if (cp[3] !== 1'b0) begin errors++; $display("FAIL byp_first got=%b want=0", cp[3]); end
    for (int i = 1; i <= 4; i++) begin
      tick();
      bp[i-1] = cp[3];
      bn[i-1] = cn[3];
    end
    checks++;
    if ({bp, bn} !== 8'b11110000) begin errors++; $display("FAIL byp_follow got=%b want=%b", {bp, bn}, 8'b11110000); end
    set_div(3, 8'd8);
    ldsw = 1'b0;
    for (int i = 5; i <= 20; i++) begin
      tick();
      vp[i-5] = cp[3];
      vn[i-5] = cn[3];
      if (i == 5) ldsw = ld[3];
    end
    checks++;
    if (ldsw !== 1'b1) begin errors++; $display("FAIL byp_load_done got=%b want=1", ldsw); end
    checks++;
    if (vp !== 16'b1110000111100001) begin errors++; $display("FAIL byp_exit_pos got=%b want=%b", vp, 16'b1110000111100001); end
    checks++;
    if (vn !== 16'b1110000111100000) begin errors++; $display("FAIL byp_exit_neg got=%b want=%b", vn, 16'b1110000111100000); end
  endtask

  task automatic test_max_ratio();
    logic [5:0] v;
    do_reset();
    set_div(0, 8'd255);
    enable[0] = 1'b1;
    tick();
    v = '0;
    for (int j = 1; j <= 384; j++) begin
      tick();
      if (j == 128) v[0] = cp[0];
      if (j == 129) v[1] = cp[0];
      if (j == 255) v[2] = cp[0];
      if (j == 257) v[3] = cp[0];
      if (j == 383) v[4] = cp[0];
      if (j == 384) v[5] = cp[0];
    end
    checks++;
    if (v !== 6'b100110) begin errors++; $display("FAIL max_ratio got=%b want=%b", v, 6'b100110); end
  endtask

  task automatic test_sync();
    logic [6:0] v0, v1;
    logic [4:0] w0;
    logic       ld14, idle_seen;
    do_reset();
    set_div(0, 8'd4);
    set_div(1, 8'd6);
    enable = 4'b0011;
    tick();
    idle_seen = 1'b0;
    ld14 = 1'b0;
    for (int j = 1; j <= 18; j++) begin
      if (j == 6) sync = 1'b1;
      if (j == 14) begin
        set_div(0, 8'd2);
        sync = 1'b1;
      end
      tick();
      sync = 1'b0;
      if (j >= 6 && j <= 12) begin
        v0[j-6] = cp[0];
        v1[j-6] = cp[1];
      end
      if (j == 6) idle_seen = cp[2] | ac[2];
      if (j == 14) ld14 = ld[0];
      if (j >= 14) w0[j-14] = cp[0];
    end
    checks++;
    if (v0 !== 7'b0011000) begin errors++; $display("FAIL sync_ch0 got=%b want=%b", v0, 7'b0011000); end
    checks++;
    if (v1 !== 7'b1110000) begin errors++; $display("FAIL sync_ch1 got=%b want=%b", v1, 7'b1110000); end
    checks++;
    if (idle_seen !== 1'b0) begin errors++; $display("FAIL sync_idle_ch2 got=%b want=0", idle_seen); end
    checks++;
    if (ld14 !== 1'b1) begin errors++; $display("FAIL sync_wrap_load got=%b want=1", ld14); end
    checks++;
    if (w0 !== 5'b10100) begin errors++; $display("FAIL sync_wrap_pos got=%b want=%b", w0, 5'b10100); end
  endtask

  task automatic test_drain();
    logic [13:0] vp, va;
    logic [7:0]  rp, ra;
    do_reset();
    set_div(0, 8'd10);
    enable[0] = 1'b1;
    tick();
    for (int j = 1; j <= 14; j++) begin
      tick();
      vp[j-1] = cp[0];
      va[j-1] = ac[0];
      if (j == 3) enable[0] = 1'b0;
    end
    checks++;
    if (vp !== 14'b00001111100000) begin errors++; $display("FAIL drain_pos got=%b want=%b", vp, 14'b00001111100000); end
    checks++;
    if (va !== 14'b00000111111111) begin errors++; $display("FAIL drain_active got=%b want=%b", va, 14'b00000111111111); end

    do_reset();
    set_div(1, 8'd4);
    enable[1] = 1'b1;
    tick();
    for (int j = 1; j <= 8; j++) begin
      tick();
      rp[j-1] = cp[1];
      ra[j-1] = ac[1];
      if (j == 1) enable[1] = 1'b0;
      if (j == 2) enable[1] = 1'b1;
    end
    checks++;
    if (rp !== 8'b11001100) begin errors++; $display("FAIL reenable_pos got=%b want=%b", rp, 8'b11001100); end
    checks++;
    if (ra !== 8'b11111111) begin errors++; $display("FAIL reenable_active got=%b want=%b", ra, 8'b11111111); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_div(0, 8'd10);
    enable[0] = 1'b1;
    tick();
    for (int j = 1; j <= 6; j++) tick();
    checks++;
    if (clkout[0] !== 1'b1) begin errors++; $display("FAIL areset_pre_high got=%b want=1", clkout[0]); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({clkout[0], active[0]} !== 2'b00) begin
      errors++; $display("FAIL areset_drop got=%b want=%b", {clkout[0], active[0]}, 2'b00);
    end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_ratio_change();
    test_bypass();
    test_max_ratio();
    test_sync();
    test_drain();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
